// File: rtl/i2cmb_wb_cmd_sequencer.sv
// Wishbone master that turns one single-byte I2C request into the full iicmb
// command sequence (enable, set-bus, start, address, data, stop) and returns one response.
module i2cmb_wb_cmd_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int NUM_I2C_BUSSES = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_rw_i,
  input  logic [3:0]               req_bus_i,
  input  logic [6:0]               req_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] req_data_i,
  output logic                     rsp_valid_o,
  output logic [1:0]               rsp_status_o,
  output logic [WB_DATA_WIDTH-1:0] rsp_data_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i,
  input  logic                     irq_i
);

  localparam int TMR_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [31:0] BUS_LIMIT = 32'(NUM_I2C_BUSSES);

  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(2'd0);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(2'd1);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2'd2);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_NAK = 2'b01;
  localparam logic [1:0] ST_AL  = 2'b10;
  localparam logic [1:0] ST_ERR = 2'b11;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WR_DPR, S_WR_CMDR, S_WAIT_IRQ, S_RD_CMDR, S_RD_DPR
  } state_t;

  typedef enum logic [2:0] {
    STEP_SET_BUS, STEP_START, STEP_ADDR, STEP_DATA, STEP_STOP
  } step_t;

  typedef enum logic [1:0] { OUT_DON, OUT_NAK, OUT_AL, OUT_ERR } outcome_t;

  function automatic logic [WB_DATA_WIDTH-1:0] pad8(input logic [7:0] b);
    return WB_DATA_WIDTH'(b);
  endfunction

  // A timed-out wait or a status byte with no recognised flag counts as an error.
  function automatic outcome_t decode_cmdr(input logic [7:0] s, input logic timed_out);
    if (timed_out) return OUT_ERR;
    else if (s[7]) return OUT_DON;
    else if (s[6]) return OUT_NAK;
    else if (s[5]) return OUT_AL;
    else return OUT_ERR;
  endfunction

  state_t                   state_q, state_d;
  step_t                    step_q, step_d;
  logic                     rw_q, rw_d;
  logic [3:0]               bus_q, bus_d;
  logic [6:0]               addr_q, addr_d;
  logic [WB_DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]               status_q, status_d;
  logic [WB_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic                     timed_out_q, timed_out_d;
  logic                     cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  logic                     ready_q, ready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [1:0]               rsp_status_q, rsp_status_d;
  logic [WB_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                     wb_req, wb_we, wb_done;
  logic [WB_ADDR_WIDTH-1:0] wb_adr;
  logic [WB_DATA_WIDTH-1:0] wb_dat;
  outcome_t                 outcome;

  assign wb_done = cyc_q & ack_i;
  assign outcome = decode_cmdr(dat_i[7:0], timed_out_q);

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    rw_d         = rw_q;
    bus_d        = bus_q;
    addr_d       = addr_q;
    data_d       = data_q;
    status_d     = status_q;
    rd_data_d    = rd_data_q;
    timer_d      = timer_q;
    timed_out_d  = timed_out_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    wb_req       = 1'b0;
    wb_we        = 1'b0;
    wb_adr       = ADR_CSR;
    wb_dat       = '0;

    case (state_q)
      S_INIT: begin
        wb_req = 1'b1;
        wb_we  = 1'b1;
        wb_adr = ADR_CSR;
        wb_dat = pad8(8'hC0);
        if (wb_done) state_d = S_IDLE;
        else state_d = S_INIT;
      end
      S_IDLE: begin
        if (req_valid_i && ready_q) begin
          rw_d      = req_rw_i;
          bus_d     = req_bus_i;
          addr_d    = req_addr_i;
          data_d    = req_data_i;
          status_d  = ST_OK;
          rd_data_d = '0;
          step_d    = STEP_SET_BUS;
          if (32'(req_bus_i) >= BUS_LIMIT) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_ERR;
            rsp_data_d   = '0;
            state_d      = S_IDLE;
          end else begin
            state_d = S_WR_DPR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_DPR: begin
        wb_req = 1'b1;
        wb_we  = 1'b1;
        wb_adr = ADR_DPR;
        case (step_q)
          STEP_SET_BUS: wb_dat = pad8({4'h0, bus_q});
          STEP_ADDR:    wb_dat = pad8({addr_q, rw_q});
          STEP_DATA:    wb_dat = data_q;
          default:      wb_dat = '0;
        endcase
        if (wb_done) state_d = S_WR_CMDR;
        else state_d = S_WR_DPR;
      end
      S_WR_CMDR: begin
        wb_req = 1'b1;
        wb_we  = 1'b1;
        wb_adr = ADR_CMDR;
        case (step_q)
          STEP_SET_BUS: wb_dat = pad8(8'h06);
          STEP_START:   wb_dat = pad8(8'h04);
          STEP_ADDR:    wb_dat = pad8(8'h01);
          STEP_DATA:    wb_dat = rw_q ? pad8(8'h03) : pad8(8'h01);
          default:      wb_dat = pad8(8'h05);
        endcase
        if (wb_done) begin
          timer_d     = '0;
          timed_out_d = 1'b0;
          state_d     = S_WAIT_IRQ;
        end else begin
          state_d = S_WR_CMDR;
        end
      end
      S_WAIT_IRQ: begin
        if (irq_i) begin
          state_d = S_RD_CMDR;
        end else if (timer_q >= TMR_MAX) begin
          timed_out_d = 1'b1;
          state_d     = S_RD_CMDR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RD_CMDR: begin
        wb_req = 1'b1;
        wb_adr = ADR_CMDR;
        // Reading CMDR also clears the controller's irq.
        if (!wb_done) begin
          state_d = S_RD_CMDR;
        end else if (step_q == STEP_STOP) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = (outcome == OUT_DON) ? status_q : ((outcome == OUT_AL) ? ST_AL : ST_ERR);
          rsp_data_d   = rw_q ? rd_data_q : '0;
          state_d      = S_IDLE;
        end else begin
          case (outcome)
            OUT_DON: begin
              case (step_q)
                STEP_SET_BUS: begin step_d = STEP_START; state_d = S_WR_CMDR; end
                STEP_START:   begin step_d = STEP_ADDR;  state_d = S_WR_DPR;  end
                STEP_ADDR: begin
                  step_d  = STEP_DATA;
                  state_d = rw_q ? S_WR_CMDR : S_WR_DPR;
                end
                STEP_DATA: begin
                  if (rw_q) begin
                    state_d = S_RD_DPR;
                  end else begin
                    step_d  = STEP_STOP;
                    state_d = S_WR_CMDR;
                  end
                end
                default: begin step_d = STEP_STOP; state_d = S_WR_CMDR; end
              endcase
            end
            OUT_NAK: begin
              status_d = ST_NAK;
              step_d   = STEP_STOP;
              state_d  = S_WR_CMDR;
            end
            OUT_AL: begin
              // Bus is no longer ours, so no stop is issued.
              rsp_valid_d  = 1'b1;
              rsp_status_d = ST_AL;
              rsp_data_d   = rw_q ? rd_data_q : '0;
              state_d      = S_IDLE;
            end
            default: begin
              status_d = ST_ERR;
              step_d   = STEP_STOP;
              state_d  = S_WR_CMDR;
            end
          endcase
        end
      end
      S_RD_DPR: begin
        wb_req = 1'b1;
        wb_adr = ADR_DPR;
        if (wb_done) begin
          rd_data_d = dat_i;
          step_d    = STEP_STOP;
          state_d   = S_WR_CMDR;
        end else begin
          state_d = S_RD_DPR;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Controls drop in the cycle after ack, which forces one idle cycle between accesses.
    if (wb_req && !wb_done) begin
      cyc_d = 1'b1;
      stb_d = 1'b1;
      we_d  = wb_we;
      adr_d = wb_adr;
      dat_d = wb_dat;
    end else begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
      we_d  = 1'b0;
      adr_d = '0;
      dat_d = '0;
    end

    ready_d = (state_d == S_IDLE);
  end

  // State and registered outputs; rst_i is synchronous.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_INIT;
      step_q       <= STEP_SET_BUS;
      rw_q         <= 1'b0;
      bus_q        <= 4'h0;
      addr_q       <= 7'h00;
      data_q       <= '0;
      status_q     <= ST_OK;
      rd_data_q    <= '0;
      timer_q      <= '0;
      timed_out_q  <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      ready_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 2'b00;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      rw_q         <= rw_d;
      bus_q        <= bus_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      status_q     <= status_d;
      rd_data_q    <= rd_data_d;
      timer_q      <= timer_d;
      timed_out_q  <= timed_out_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      ready_q      <= ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_status_o = rsp_status_q;
  assign rsp_data_o   = rsp_data_q;
  assign cyc_o        = cyc_q;
  assign stb_o        = stb_q;
  assign we_o         = we_q;
  assign adr_o        = adr_q;
  assign dat_o        = dat_q;

endmodule

// File: tb/tb_i2cmb_wb_cmd_sequencer.sv
// Directed bench: a small iicmb register model answers the Wishbone master and
// every access is logged as {we, adr, data} for comparison with hand-built sequences.
module tb_i2cmb_wb_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_rw;
  logic [3:0] req_bus;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [1:0] rsp_status;
  logic [7:0] rsp_data;
  logic       cyc, stb, we;
  logic [1:0] adr;
  logic [7:0] dat_o, dat_i;
  logic       ack, irq;

  i2cmb_wb_cmd_sequencer #(
    .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .NUM_I2C_BUSSES(1), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
    .req_bus_i(req_bus), .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_status_o(rsp_status), .rsp_data_o(rsp_data),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack), .irq_i(irq)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // iicmb register model
  logic [15:0] log_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  dpr_reg, cmdr_stat, rd_byte, nak_byte;
  bit          irq_mute, nak_en;
  int          irq_cnt;

  always @(posedge clk) begin
    if (rst) begin
      ack       <= 1'b0;
      irq       <= 1'b0;
      dat_i     <= 8'h00;
      irq_cnt   <= 0;
      dpr_reg   <= 8'h00;
      cmdr_stat <= 8'h00;
    end else begin
      ack <= 1'b0;
      if (irq_cnt > 0) begin
        irq_cnt <= irq_cnt - 1;
        if (irq_cnt == 1 && !irq_mute) irq <= 1'b1;
      end
      if (cyc && stb && !ack) begin
        ack <= 1'b1;
        if (we) begin
          dat_i <= 8'h00;
          log_q.push_back({3'b000, we, 2'b00, adr, dat_o});
          if (adr == 2'd1) dpr_reg <= dat_o;
          if (adr == 2'd2) begin
            cmdr_stat <= (dat_o == 8'h01 && nak_en && dpr_reg == nak_byte) ? 8'h40 : 8'h80;
            irq_cnt   <= 3;
          end
        end else if (adr == 2'd2) begin
          dat_i <= cmdr_stat;
          irq   <= 1'b0;
          log_q.push_back({4'h0, 2'b00, adr, cmdr_stat});
        end else if (adr == 2'd1) begin
          dat_i <= rd_byte;
          log_q.push_back({4'h0, 2'b00, adr, rd_byte});
        end else begin
          dat_i <= 8'h00;
          log_q.push_back({4'h0, 2'b00, adr, 8'h00});
        end
      end
    end
  end

  // Response pulses and back-to-back Wishbone cycle detection.
  int rsp_cnt  = 0;
  int b2b_viol = 0;
  logic prev_ack = 1'b0;
  always @(posedge clk) begin
    if (rsp_valid) rsp_cnt++;
    if (prev_ack && cyc) b2b_viol++;
    prev_ack <= ack && cyc;
  end

  task automatic chk_log(input string tag, input int base);
    chk({tag, "_len"}, 32'(log_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < log_q.size())
        chk($sformatf("%s[%0d]", tag, i), 32'(log_q[base + i]), 32'(exp_q[i]));
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Issue one request, wait for its response; lat counts cycles after acceptance.
  task automatic do_req(input string tag, input logic rw, input logic [3:0] bus,
                        input logic [6:0] a, input logic [7:0] d, input int budget,
                        output int lat, output logic [1:0] st, output logic [7:0] rd);
    int n = 0;
    wait_ready(tag);
    req_valid = 1'b1; req_rw = rw; req_bus = bus; req_addr = a; req_data = d;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
    lat = n;
    st  = rsp_status;
    rd  = rsp_data;
    @(negedge clk);
    chk({tag, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_status_hold"}, 32'(rsp_status), 32'(st));
  endtask

  initial begin
    int base, r0, lat, n;
    logic [1:0] st;
    logic [7:0] rd;

    rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_bus = 4'h0;
    req_addr = 7'h00; req_data = 8'h00;
    irq_mute = 1'b0; nak_en = 1'b0; nak_byte = 8'h00; rd_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_wb", 32'({cyc, stb, we, adr, dat_o}), 32'd0);
    chk("reset_rsp", 32'({req_ready, rsp_valid, rsp_status, rsp_data}), 32'd0);

    base = log_q.size();
    rst = 1'b0;
    wait_ready("init");
    exp_q = '{16'h10C0};
    chk_log("init_log", base);
    repeat (20) @(negedge clk);
    chk("init_idle_len", 32'(log_q.size() - base), 32'd1);

    // Write 0xA5 to 0x22 on bus 0
    base = log_q.size(); r0 = rsp_cnt;
    do_req("wr", 1'b0, 4'd0, 7'h22, 8'hA5, 1000, lat, st, rd);
    chk("wr_status", 32'(st), 32'd0);
    chk("wr_data", 32'(rd), 32'd0);
    chk("wr_rsp_cnt", 32'(rsp_cnt - r0), 32'd1);
    exp_q = '{16'h1100, 16'h1206, 16'h0280, 16'h1204, 16'h0280, 16'h1144, 16'h1201,
              16'h0280, 16'h11A5, 16'h1201, 16'h0280, 16'h1205, 16'h0280};
    chk_log("wr_log", base);

    // Read from 0x22, slave returns 0x3C
    rd_byte = 8'h3C;
    base = log_q.size();
    do_req("rd", 1'b1, 4'd0, 7'h22, 8'h00, 1000, lat, st, rd);
    chk("rd_status", 32'(st), 32'd0);
    chk("rd_data", 32'(rd), 32'h3C);
    exp_q = '{16'h1100, 16'h1206, 16'h0280, 16'h1204, 16'h0280, 16'h1145, 16'h1201,
              16'h0280, 16'h1203, 16'h0280, 16'h013C, 16'h1205, 16'h0280};
    chk_log("rd_log", base);

    // Address 0x7F NAKed: stop follows immediately
    nak_en = 1'b1; nak_byte = 8'hFE;
    base = log_q.size(); r0 = rsp_cnt;
    do_req("nak", 1'b0, 4'd0, 7'h7F, 8'h11, 1000, lat, st, rd);
    nak_en = 1'b0;
    chk("nak_status", 32'(st), 32'd1);
    chk("nak_rsp_cnt", 32'(rsp_cnt - r0), 32'd1);
    exp_q = '{16'h1100, 16'h1206, 16'h0280, 16'h1204, 16'h0280, 16'h11FE, 16'h1201,
              16'h0240, 16'h1205, 16'h0280};
    chk_log("nak_log", base);

    // Out-of-range bus
    base = log_q.size();
    do_req("badbus", 1'b0, 4'd3, 7'h22, 8'h00, 10, lat, st, rd);
    chk("badbus_status", 32'(st), 32'd3);
    chk("badbus_fast", 32'(lat <= 1), 32'd1);
    chk("badbus_no_wb", 32'(log_q.size() - base), 32'd0);

    // irq never arrives: set-bus and stop each time out
    irq_mute = 1'b1;
    base = log_q.size();
    do_req("tmo", 1'b0, 4'd0, 7'h22, 8'h5A, 1000, lat, st, rd);
    chk("tmo_status", 32'(st), 32'd3);
    chk("tmo_latency", 32'(lat >= 200 && lat < 300), 32'd1);
    exp_q = '{16'h1100, 16'h1206, 16'h0280, 16'h1205, 16'h0280};
    chk_log("tmo_log", base);
    irq_mute = 1'b0;

    // Reset while waiting for the start command's irq
    base = log_q.size();
    wait_ready("rst");
    req_valid = 1'b1; req_rw = 1'b0; req_bus = 4'd0; req_addr = 7'h22; req_data = 8'h77;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (log_q.size() - base < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    irq_mute = 1'b1;
    chk("rst_reached_start", 32'(log_q.size() - base), 32'd4);
    repeat (4) @(negedge clk);
    r0 = rsp_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    irq_mute = 1'b0;
    base = log_q.size();
    wait_ready("rst_init");
    exp_q = '{16'h10C0};
    chk_log("rst_log", base);
    chk("rst_no_rsp", 32'(rsp_cnt - r0), 32'd0);

    // Normal operation after the abort
    do_req("post", 1'b0, 4'd0, 7'h10, 8'h3A, 1000, lat, st, rd);
    chk("post_status", 32'(st), 32'd0);
    chk("no_back_to_back", 32'(b2b_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
